// File: rtl/pmc_io_regs_if.sv
// Ibex-style data bus used for register access to the PMC I/O block.
interface ibex_data_bus;
   logic        req;
   logic        gnt;
   logic        rvalid;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        err;

   modport slave  (input  req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
   modport master (output req, we, be, addr, wdata, input  gnt, rvalid, rdata, err);
endinterface

// File: rtl/pmc_io_regs.sv
// Pixel-matrix controller register file with a capture FIFO of pm_dout samples.
// Optional capture counter enabled by defining PMC_IO_REGS_CAPTURE_CNT_EN.
module pmc_io_regs #(
   parameter int unsigned NW    = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   ibex_data_bus.slave       data_bus,
   output logic [32*NW-1:0]  pm_din,
   input  logic [32*NW-1:0]  pm_dout,
   input  logic              cap_strobe,
   input  logic              waitt,
   output logic              pmcc_rst_n,
   output logic              pmcc_trg
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic [7:0]        off;
   logic              rd_acc, wr_acc, cr_wr;
   logic              en_q, trg_q, rst_q, clr_ovf_q, cap_sw_q, flush_q;
   logic [31:0]       din_q [NW];
   logic              waitt_q, strobe_q, ovf_q;
   logic [LW-1:0]     level_q, level_d;
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [32*NW-1:0]  mem [DEPTH];
   logic              rvalid_q;
   logic [31:0]       rdata_q, rdata_d, sr, cnt_rd;
   logic              empty, full, cap_evt, pop, push_ok, ovf_set;
   logic              unused_bits;

   assign off    = data_bus.addr[9:2];
   assign rd_acc = data_bus.req & ~data_bus.we;
   assign wr_acc = data_bus.req & data_bus.we;
   assign cr_wr  = wr_acc & (off == 8'h00);

   assign data_bus.gnt    = data_bus.req;
   assign data_bus.rvalid = rvalid_q;
   assign data_bus.rdata  = rdata_q;
   assign data_bus.err    = 1'b0;
   assign unused_bits     = ^{data_bus.be, data_bus.addr[31:10], data_bus.addr[1:0]};

   assign pmcc_rst_n = en_q & ~rst_q;
   assign pmcc_trg   = trg_q;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LW'(DEPTH));
   // Strobe edge and software capture in the same cycle collapse into one push.
   assign cap_evt = (cap_strobe & ~strobe_q) | cap_sw_q;
   assign pop     = rd_acc & (off == 8'h20 + 8'(NW - 1)) & ~empty;
   assign push_ok = cap_evt & (~full | pop);
   assign ovf_set = cap_evt & full & ~pop & ~flush_q;

   always_comb begin
      pm_din = '0;
      for (int unsigned k = 0; k < NW; k++) pm_din[32*k +: 32] = din_q[k];
   end

   always_comb begin
      level_d = level_q;
      if (push_ok && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push_ok) level_d = level_q - LW'(1);
   end

   always_comb begin
      sr            = '0;
      sr[0]         = waitt_q;
      sr[1]         = empty;
      sr[2]         = full;
      sr[3]         = ovf_q;
      sr[8 +: LW]   = level_q;
   end

`ifdef PMC_IO_REGS_CAPTURE_CNT_EN
   logic [31:0] cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt_q <= '0;
      else if (flush_q) cnt_q <= '0;
      else if (push_ok) cnt_q <= cnt_q + 32'd1;
   end
   assign cnt_rd = cnt_q;
`else
   assign cnt_rd = '0;
`endif

   always_comb begin
      rdata_d = '0;
      case (off)
         8'h00:   rdata_d = {26'b0, flush_q, cap_sw_q, clr_ovf_q, rst_q, trg_q, en_q};
         8'h01:   rdata_d = sr;
         8'h02:   rdata_d = cnt_rd;
         default: rdata_d = '0;
      endcase
      for (int unsigned k = 0; k < NW; k++) begin
         if (off == 8'(16 + k)) rdata_d = din_q[k];
         if (off == 8'(32 + k) && !empty) rdata_d = mem[rd_ptr_q][32*k +: 32];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q      <= 1'b0;
         trg_q     <= 1'b0;
         rst_q     <= 1'b0;
         clr_ovf_q <= 1'b0;
         cap_sw_q  <= 1'b0;
         flush_q   <= 1'b0;
         for (int unsigned k = 0; k < NW; k++) din_q[k] <= '0;
         waitt_q   <= 1'b0;
         strobe_q  <= 1'b0;
         ovf_q     <= 1'b0;
         level_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (cr_wr) en_q <= data_bus.wdata[0];
         {flush_q, cap_sw_q, clr_ovf_q, rst_q, trg_q} <= cr_wr ? data_bus.wdata[5:1] : 5'b0;
         for (int unsigned k = 0; k < NW; k++)
            if (wr_acc && off == 8'(16 + k)) din_q[k] <= data_bus.wdata;
         waitt_q  <= waitt;
         strobe_q <= cap_strobe;
         if (ovf_set)        ovf_q <= 1'b1;
         else if (clr_ovf_q) ovf_q <= 1'b0;
         if (flush_q) begin
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            level_q <= level_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         rvalid_q <= data_bus.req;
         rdata_q  <= rd_acc ? rdata_d : '0;
      end
   end

   // When full, push and pop share a slot: the head is read before it is overwritten.
   always_ff @(posedge clk) begin
      if (push_ok && !flush_q) mem[wr_ptr_q] <= pm_dout;
   end
endmodule

// File: tb/tb_pmc_io_regs.sv
// Directed bench for pmc_io_regs (NW=2, DEPTH=4).
module tb_pmc_io_regs;
   localparam int unsigned NW    = 2;
   localparam int unsigned DEPTH = 4;

`ifdef PMC_IO_REGS_CAPTURE_CNT_EN
   localparam logic [31:0] CNT_ON = 32'd1;
`else
   localparam logic [31:0] CNT_ON = 32'd0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [63:0]      pm_din, pm_dout;
   logic             cap_strobe, waitt, pmcc_rst_n, pmcc_trg;
   int               n_cmp = 0;
   int               n_bad = 0;

   always #5 clk = ~clk;

   ibex_data_bus bus ();

   pmc_io_regs #(.NW(NW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_bus   (bus),
      .pm_din     (pm_din),
      .pm_dout    (pm_dout),
      .cap_strobe (cap_strobe),
      .waitt      (waitt),
      .pmcc_rst_n (pmcc_rst_n),
      .pmcc_trg   (pmcc_trg)
   );

   typedef struct {
      logic        we;
      logic [7:0]  off;
      logic [31:0] data;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = {22'b0, off, 2'b0}; bus.wdata = d;
      @(negedge clk);
      bus.req = 1'b0; bus.we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] d);
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = {22'b0, off, 2'b0};
      #1 check("gnt", {63'b0, bus.gnt}, 64'd1);
      @(negedge clk);
      bus.req = 1'b0;
      check("rvalid", {63'b0, bus.rvalid}, 64'd1);
      d = bus.rdata;
   endtask

   task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
      logic [31:0] v;
      rd(off, v);
      check(name, {32'b0, v}, {32'b0, exp});
   endtask

   task automatic cap_sw_push(input logic [63:0] v);
      pm_dout = v;
      wr(8'h00, 32'h11);
      @(negedge clk);
   endtask

   function automatic logic [63:0] samp(input int i);
      return {32'h1100_0000 + i, 32'h2200_0000 + i};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] s;
      int          order [4];

      bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'hF; bus.addr = '0; bus.wdata = '0;
      pm_dout = '0; cap_strobe = 1'b0; waitt = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("reset_pm_din",     pm_din, 64'd0);
      check("reset_pmcc_rst_n", {63'b0, pmcc_rst_n}, 64'd0);
      check("reset_pmcc_trg",   {63'b0, pmcc_trg}, 64'd0);
      check("reset_rvalid",     {63'b0, bus.rvalid}, 64'd0);
      check("reset_err",        {63'b0, bus.err}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      vecs[0]  = '{1'b1, 8'h10, 32'hA5A5_A5A5};
      vecs[1]  = '{1'b1, 8'h11, 32'h5A5A_5A5A};
      vecs[2]  = '{1'b0, 8'h10, 32'hA5A5_A5A5};
      vecs[3]  = '{1'b0, 8'h11, 32'h5A5A_5A5A};
      vecs[4]  = '{1'b0, 8'h7F, 32'h0};
      vecs[5]  = '{1'b0, 8'h01, 32'h2};
      vecs[6]  = '{1'b0, 8'h02, 32'h0};
      vecs[7]  = '{1'b0, 8'h20, 32'h0};
      vecs[8]  = '{1'b1, 8'h12, 32'hDEAD_BEEF};
      vecs[9]  = '{1'b0, 8'h12, 32'h0};
      vecs[10] = '{1'b1, 8'h00, 32'h1};
      vecs[11] = '{1'b0, 8'h00, 32'h1};
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].we) wr(vecs[i].off, vecs[i].data);
         else            rd_chk($sformatf("vec%0d_off%0h", i, vecs[i].off), vecs[i].off, vecs[i].data);
      end
      check("pm_din_din", pm_din, 64'h5A5A_5A5A_A5A5_A5A5);
      check("en_rst_n",   {63'b0, pmcc_rst_n}, 64'd1);

      // CR pulses
      wr(8'h00, 32'h3);
      check("trg_pulse",   {63'b0, pmcc_trg}, 64'd1);
      check("rst_n_trg",   {63'b0, pmcc_rst_n}, 64'd1);
      @(negedge clk);
      check("trg_cleared", {63'b0, pmcc_trg}, 64'd0);
      wr(8'h00, 32'h5);
      check("rst_pulse",   {63'b0, pmcc_rst_n}, 64'd0);
      @(negedge clk);
      check("rst_cleared", {63'b0, pmcc_rst_n}, 64'd1);
      rd_chk("cr_selfclr", 8'h00, 32'h1);

      // Strobe held high: single push
      pm_dout = 64'h1122_3344_5566_7788;
      @(negedge clk); cap_strobe = 1'b1;
      repeat (3) @(negedge clk);
      cap_strobe = 1'b0;
      rd_chk("strb_sr",    8'h01, 32'h100);
      rd_chk("strb_dout0", 8'h20, 32'h5566_7788);
      rd_chk("strb_sr2",   8'h01, 32'h100);
      rd_chk("strb_dout1", 8'h21, 32'h1122_3344);
      rd_chk("strb_sr3",   8'h01, 32'h2);
      rd_chk("strb_cnt",   8'h02, CNT_ON);
      wr(8'h00, 32'h21);
      rd_chk("flush_cnt",  8'h02, 32'h0);

      // Overflow
      for (int i = 0; i < 5; i++) cap_sw_push(samp(i));
      rd_chk("ovf_sr",   8'h01, 32'h40C);
      rd_chk("ovf_cnt",  8'h02, CNT_ON * 4);
      wr(8'h00, 32'h09);
      rd_chk("clr_ovf",  8'h01, 32'h404);

      // Full: cap_sw coincident with the popping read
      @(negedge clk);
      pm_dout = samp(5);
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h0; bus.wdata = 32'h11;
      @(negedge clk);
      bus.we = 1'b0; bus.addr = {22'b0, 8'h21, 2'b0};
      @(negedge clk);
      bus.req = 1'b0;
      s = samp(0);
      check("pp_rvalid", {63'b0, bus.rvalid}, 64'd1);
      check("pp_rdata",  {32'b0, bus.rdata}, {32'b0, s[63:32]});
      rd_chk("pp_sr",  8'h01, 32'h404);
      rd_chk("pp_cnt", 8'h02, CNT_ON * 5);
      order = '{1, 2, 3, 5};
      for (int i = 0; i < 4; i++) begin
         s = samp(order[i]);
         rd_chk($sformatf("drain%0d_lo", i), 8'h20, s[31:0]);
         rd_chk($sformatf("drain%0d_hi", i), 8'h21, s[63:32]);
      end
      rd_chk("drain_sr", 8'h01, 32'h2);

      // Flush beats coincident push
      cap_sw_push(samp(6));
      rd_chk("pre_flush_sr", 8'h01, 32'h100);
      wr(8'h00, 32'h31);
      @(negedge clk);
      rd_chk("flush_prio_sr", 8'h01, 32'h2);

      // Reset while a DOUT read is pending
      cap_sw_push(samp(7));
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = {22'b0, 8'h20, 2'b0};
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_rvalid",  {63'b0, bus.rvalid}, 64'd0);
      check("rst_pm_din",  pm_din, 64'd0);
      check("rst_pmcc",    {63'b0, pmcc_rst_n}, 64'd0);
      bus.addr = {22'b0, 8'h01, 2'b0};
      rst_n = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
      check("post_rst_rvalid", {63'b0, bus.rvalid}, 64'd1);
      check("post_rst_sr",     {32'b0, bus.rdata}, 64'h2);
      rd_chk("post_rst_din0",  8'h10, 32'h0);

      waitt = 1'b1;
      @(negedge clk);
      rd_chk("waitt_sr", 8'h01, 32'h3);
      waitt = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
